// File: rtl/dec_n_scan_if.sv
// Select/strobe bundle between a controller and dec_n_scan.
// master drives select/control; slave returns decoded lines, index and wrap pulse.
interface dec_n_scan_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 1 << SEL_W;

  logic             EN;
  logic             mode;
  logic [SEL_W-1:0] a;
  logic             load;
  logic [OUT_W-1:0] OUT;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output EN, mode, a, load,
    input  OUT, idx, wrap
  );

  modport slave (
    input  EN, mode, a, load,
    output OUT, idx, wrap
  );
endinterface

// File: rtl/dec_n_scan.sv
// Registered SEL_W -> 2**SEL_W one-hot/one-cold decoder with prescaled auto-scan.
// One-cycle latency from a/EN/load to OUT/idx/wrap; no backpressure, input accepted every clock.
module dec_n_scan #(
  parameter int SEL_W      = 2,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dec_n_scan_if.slave bus
);
  localparam int                OUT_W     = 1 << SEL_W;
  localparam int                PCNT_W    = $clog2(PRESCALE) + 1;
  localparam logic [OUT_W-1:0]  IDLE      = {OUT_W{ACTIVE_LOW}};
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]  IDX_MAX   = '1;

  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  idx_nxt;
  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_nxt;
  logic              wrap_q;
  logic              wrap_nxt;
  logic [OUT_W-1:0]  out_q;

  // Next index is shared by idx and OUT so both move on the same edge.
  always_comb begin
    idx_nxt  = idx_q;
    pcnt_nxt = pcnt_q;
    wrap_nxt = 1'b0;
    if (bus.EN) begin
      if (!bus.mode || bus.load) begin
        idx_nxt  = bus.a;
        pcnt_nxt = '0;
      end else if (pcnt_q == PCNT_LAST) begin
        pcnt_nxt = '0;
        idx_nxt  = idx_q + SEL_W'(1);
        wrap_nxt = (idx_q == IDX_MAX);
      end else begin
        pcnt_nxt = pcnt_q + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= IDLE;
      idx_q  <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_nxt;
      pcnt_q <= pcnt_nxt;
      wrap_q <= wrap_nxt;
      out_q  <= bus.EN ? ((OUT_W'(1) << idx_nxt) ^ IDLE) : IDLE;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_dec_n_scan.sv
// Bench for dec_n_scan: two configurations checked every cycle against a behavioural model.
module tb_dec_n_scan;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  dec_n_scan_if #(.SEL_W(2)) ia ();
  dec_n_scan_if #(.SEL_W(3)) ib ();

  dec_n_scan #(.SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .bus(ia.slave));
  dec_n_scan #(.SEL_W(3), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .bus(ib.slave));

  int vecs = 0;
  int miss = 0;
  bit chk = 1'b0;

  typedef struct {
    int idx;
    int pcnt;
    bit wrap;
    bit on;
  } mst_t;

  mst_t ma = '{0, 0, 1'b0, 1'b0};
  mst_t mb = '{0, 0, 1'b0, 1'b0};

  // Behaviour of one clock edge, from the priority rst > EN=0 > load > step.
  function automatic mst_t mstep(mst_t s, bit r, bit en, bit md, bit ld, int a, int n, int p);
    mst_t t = s;
    t.wrap = 1'b0;
    if (r) begin
      t.idx = 0; t.pcnt = 0; t.on = 1'b0;
    end else if (!en) begin
      t.on = 1'b0;
    end else begin
      t.on = 1'b1;
      if (!md || ld) begin
        t.idx = a; t.pcnt = 0;
      end else if (s.pcnt == p - 1) begin
        t.pcnt = 0;
        t.wrap = (s.idx == n - 1);
        t.idx  = (s.idx + 1) % n;
      end else begin
        t.pcnt = s.pcnt + 1;
      end
    end
    return t;
  endfunction

  function automatic int exp_out(mst_t s, int n, bit al);
    int v = s.on ? (1 << s.idx) : 0;
    if (al) v = v ^ ((1 << n) - 1);
    return v;
  endfunction

  task automatic cmp(string name, int got, int exp);
    vecs++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = mstep(ma, rst_a, ia.EN, ia.mode, ia.load, int'(ia.a), 4, 4);
    mb = mstep(mb, rst_b, ib.EN, ib.mode, ib.load, int'(ib.a), 8, 1);
    chk = 1'b1;
  end

  always @(negedge clk) begin
    if (chk) begin
      cmp("A.OUT",  int'(ia.OUT),  exp_out(ma, 4, 1'b0));
      cmp("A.idx",  int'(ia.idx),  ma.idx);
      cmp("A.wrap", int'(ia.wrap), int'(ma.wrap));
      cmp("B.OUT",  int'(ib.OUT),  exp_out(mb, 8, 1'b1));
      cmp("B.idx",  int'(ib.idx),  mb.idx);
      cmp("B.wrap", int'(ib.wrap), int'(mb.wrap));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int wc;
    ia.EN = 1'b0; ia.mode = 1'b0; ia.a = '0; ia.load = 1'b0;
    ib.EN = 1'b1; ib.mode = 1'b1; ib.a = '0; ib.load = 1'b0;

    // Reset, then direct mode with EN low: everything idle.
    tick(2);
    rst_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ia.a = 2'(k);
      tick(1);
      cmp("lit.dis_out", int'(ia.OUT), 0);
      cmp("lit.dis_idx", int'(ia.idx), 0);
    end

    // Direct decode.
    ia.EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ia.a = 2'(k);
      tick(1);
      cmp("lit.dir_out", int'(ia.OUT), 1 << k);
      cmp("lit.dir_idx", int'(ia.idx), k);
    end

    // Scan from idx 0 for 20 clocks: steps every 4, one wrap.
    ia.mode = 1'b1; ia.load = 1'b1; ia.a = 2'd0;
    tick(1);
    ia.load = 1'b0;
    wc = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (ia.wrap) wc++;
    end
    cmp("lit.scan_wraps", wc, 1);
    cmp("lit.scan_idx", int'(ia.idx), 1);

    // Freeze at idx=1, pcnt=2, then resume.
    ia.load = 1'b1; ia.a = 2'd1;
    tick(1);
    ia.load = 1'b0;
    tick(2);
    ia.EN = 1'b0;
    tick(5);
    cmp("lit.frz_out", int'(ia.OUT), 0);
    cmp("lit.frz_idx", int'(ia.idx), 1);
    ia.EN = 1'b1;
    tick(1);
    cmp("lit.res1_out", int'(ia.OUT), 4'b0010);
    cmp("lit.res1_idx", int'(ia.idx), 1);
    tick(1);
    cmp("lit.res2_idx", int'(ia.idx), 2);
    cmp("lit.res2_out", int'(ia.OUT), 4'b0100);

    // Load 3, then wrap to 0 four clocks later.
    ia.load = 1'b1; ia.a = 2'd3;
    tick(1);
    ia.load = 1'b0;
    cmp("lit.ld_idx", int'(ia.idx), 3);
    cmp("lit.ld_out", int'(ia.OUT), 4'b1000);
    tick(3);
    cmp("lit.ld_hold", int'(ia.idx), 3);
    tick(1);
    cmp("lit.ld_wrap_idx", int'(ia.idx), 0);
    cmp("lit.ld_wrap", int'(ia.wrap), 1);

    // One-cold, PRESCALE=1 instance: steps every clock, reset mid-scan.
    rst_b = 1'b0;
    tick(10);
    cmp("lit.b_idx", int'(ib.idx), 2);
    cmp("lit.b_out", int'(ib.OUT), 8'hFB);
    rst_b = 1'b1;
    tick(1);
    cmp("lit.b_rst_out", int'(ib.OUT), 8'hFF);
    cmp("lit.b_rst_idx", int'(ib.idx), 0);
    rst_b = 1'b0;

    // Randomized traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      ia.EN   = ($urandom_range(0, 7) != 0);
      ia.mode = ($urandom_range(0, 3) != 0);
      ia.load = ($urandom_range(0, 9) == 0);
      ia.a    = 2'($urandom_range(0, 3));
      rst_a   = ($urandom_range(0, 79) == 0);
      ib.EN   = ($urandom_range(0, 7) != 0);
      ib.mode = ($urandom_range(0, 3) != 0);
      ib.load = ($urandom_range(0, 9) == 0);
      ib.a    = 3'($urandom_range(0, 7));
      rst_b   = ($urandom_range(0, 79) == 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
